soc_tick_cnt_wb: RTL and testbench

Wishbone peripheral on one of the external master slots of the E1 SoC, downstream of the tick outputs: per-channel E1 RX/TX tick strobes and the USB start-of-frame strobe. It counts the strobes and timestamps each SOF against a free-running system-cycle counter. Firmware uses it to measure E1 clock drift against USB frame timing for rate feedback.

---
 rtl/soc_tick_cnt_wb.sv | 144 ++++++++++++++
 tb/tb_soc_tick_cnt_wb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_tick_cnt_wb.sv
// soc_tick_cnt_wb: counts E1 RX/TX and USB SOF tick strobes, timestamps each
// SOF against a free-running cycle counter, and exposes everything (plus a
// firmware-triggered snapshot) on a small Wishbone register window.
//
// Wishbone handshake: an access is accepted on an edge where wb_cyc is high
// and wb_ack is low. That edge raises wb_ack for exactly one cycle, registers
// wb_rdata (the selected value as it was before the edge), and commits any
// write. wb_rdata is 0 whenever wb_ack is low. A master that keeps wb_cyc high
// gets one ack every two cycles.
module soc_tick_cnt_wb #(
    parameter int E1_N = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [E1_N-1:0] tick_e1_rx,
    input  logic [E1_N-1:0] tick_e1_tx,
    input  logic            tick_usb_sof,
    input  logic [2:0]      wb_addr,
    output logic [31:0]     wb_rdata,
    input  logic [31:0]     wb_wdata,
    input  logic            wb_we,
    input  logic            wb_cyc,
    output logic            wb_ack
);

    // Strobes widened to two channels; channel 1 is tied off when absent.
    logic [1:0] rx_tick;
    logic [1:0] tx_tick;

    generate
        if (E1_N == 2) begin : g_two_ch
            assign rx_tick = tick_e1_rx;
            assign tx_tick = tick_e1_tx;
        end else begin : g_one_ch
            assign rx_tick = {1'b0, tick_e1_rx};
            assign tx_tick = {1'b0, tick_e1_tx};
        end
    endgenerate

    // Only the two command bits of the CSR are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^wb_wdata[31:2];

    logic [15:0] rx_cnt_q [2];
    logic [15:0] rx_cnt_d [2];
    logic [15:0] tx_cnt_q [2];
    logic [15:0] tx_cnt_d [2];
    logic [15:0] sof_cnt_q, sof_cnt_d;
    logic [31:0] sof_ts_q, sof_ts_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] sh_rx0_q, sh_rx0_d;
    logic [15:0] sh_tx0_q, sh_tx0_d;
    logic [15:0] sh_rx1_q, sh_rx1_d;
    logic [15:0] sh_sof_q, sh_sof_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic        acc;
    logic        csr_wr;
    logic        clr;
    logic        snap;
    logic [31:0] rd_sel;

    // Bus decode: accepted access, CSR write and its two command bits.
    always_comb begin
        acc    = wb_cyc & ~ack_q;
        csr_wr = acc & wb_we & (wb_addr == 3'd7);
        clr    = csr_wr & wb_wdata[0];
        snap   = csr_wr & wb_wdata[1];
    end

    // Counter updates; a clear restarts from 0 but still counts a same-edge tick.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rx_cnt_d[i] = (clr ? 16'd0 : rx_cnt_q[i]) + {15'd0, rx_tick[i]};
            tx_cnt_d[i] = (clr ? 16'd0 : tx_cnt_q[i]) + {15'd0, tx_tick[i]};
        end
        sof_cnt_d = (clr ? 16'd0 : sof_cnt_q) + {15'd0, tick_usb_sof};
        sof_ts_d  = tick_usb_sof ? cyc_cnt_q : (clr ? 32'd0 : sof_ts_q);
        cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    // Snapshot copies the pre-edge (and therefore pre-clear) counter values.
    always_comb begin
        sh_rx0_d = snap ? rx_cnt_q[0] : sh_rx0_q;
        sh_tx0_d = snap ? tx_cnt_q[0] : sh_tx0_q;
        sh_rx1_d = snap ? rx_cnt_q[1] : sh_rx1_q;
        sh_sof_d = snap ? sof_cnt_q   : sh_sof_q;
    end

    // Read mux and ack generation; rdata is only non-zero in the ack cycle.
    always_comb begin
        rd_sel = 32'd0;
        case (wb_addr)
            3'd0:    rd_sel = {tx_cnt_q[0], rx_cnt_q[0]};
            3'd1:    rd_sel = (E1_N == 2) ? {tx_cnt_q[1], rx_cnt_q[1]} : 32'd0;
            3'd2:    rd_sel = {16'd0, sof_cnt_q};
            3'd3:    rd_sel = sof_ts_q;
            3'd4:    rd_sel = cyc_cnt_q;
            3'd5:    rd_sel = {sh_tx0_q, sh_rx0_q};
            3'd6:    rd_sel = {sh_sof_q, ((E1_N == 2) ? sh_rx1_q : 16'd0)};
            default: rd_sel = 32'd0;
        endcase
        ack_d   = acc;
        rdata_d = acc ? rd_sel : 32'd0;
    end

    // State registers; reset clears everything including an in-flight ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rx_cnt_q[i] <= 16'd0;
                tx_cnt_q[i] <= 16'd0;
            end
            sof_cnt_q <= 16'd0;
            sof_ts_q  <= 32'd0;
            cyc_cnt_q <= 32'd0;
            sh_rx0_q  <= 16'd0;
            sh_tx0_q  <= 16'd0;
            sh_rx1_q  <= 16'd0;
            sh_sof_q  <= 16'd0;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rx_cnt_q[i] <= rx_cnt_d[i];
                tx_cnt_q[i] <= tx_cnt_d[i];
            end
            sof_cnt_q <= sof_cnt_d;
            sof_ts_q  <= sof_ts_d;
            cyc_cnt_q <= cyc_cnt_d;
            sh_rx0_q  <= sh_rx0_d;
            sh_tx0_q  <= sh_tx0_d;
            sh_rx1_q  <= sh_rx1_d;
            sh_sof_q  <= sh_sof_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;

endmodule

// File: tb/tb_soc_tick_cnt_wb.sv
// Bench for soc_tick_cnt_wb: a two-channel instance and a one-channel instance
// share all stimulus; a transaction-level model of the register map predicts
// every ack and read value.
module tb_soc_tick_cnt_wb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  tick_e1_rx;
    logic [1:0]  tick_e1_tx;
    logic        tick_usb_sof;
    logic [2:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic [31:0] one_rdata;
    logic        one_ack;

    soc_tick_cnt_wb #(.E1_N(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_e1_rx   (tick_e1_rx),
        .tick_e1_tx   (tick_e1_tx),
        .tick_usb_sof (tick_usb_sof),
        .wb_addr      (wb_addr),
        .wb_rdata     (wb_rdata),
        .wb_wdata     (wb_wdata),
        .wb_we        (wb_we),
        .wb_cyc       (wb_cyc),
        .wb_ack       (wb_ack)
    );

    soc_tick_cnt_wb #(.E1_N(1)) dut_one (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_e1_rx   (tick_e1_rx[0]),
        .tick_e1_tx   (tick_e1_tx[0]),
        .tick_usb_sof (tick_usb_sof),
        .wb_addr      (wb_addr),
        .wb_rdata     (one_rdata),
        .wb_wdata     (wb_wdata),
        .wb_we        (wb_we),
        .wb_cyc       (wb_cyc),
        .wb_ack       (one_ack)
    );

    // ---------------- reference model ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic [15:0] m_rx [2];
    logic [15:0] m_tx [2];
    logic [15:0] m_sof;
    logic [31:0] m_ts;
    logic [31:0] m_cyc;
    logic [15:0] s_rx0, s_tx0, s_rx1, s_sof;
    logic        m_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rx[i] = 16'd0;
            m_tx[i] = 16'd0;
        end
        m_sof = 16'd0;
        m_ts  = 32'd0;
        m_cyc = 32'd0;
        s_rx0 = 16'd0;
        s_tx0 = 16'd0;
        s_rx1 = 16'd0;
        s_sof = 16'd0;
        m_ack = 1'b0;
        exp_q.delete();
    endtask

    // Register map as firmware sees it; two_ch selects the E1_N=2 view.
    function automatic logic [31:0] mval(input logic [2:0] a, input bit two_ch);
        case (a)
            3'd0:    return {m_tx[0], m_rx[0]};
            3'd1:    return two_ch ? {m_tx[1], m_rx[1]} : 32'd0;
            3'd2:    return {16'd0, m_sof};
            3'd3:    return m_ts;
            3'd4:    return m_cyc;
            3'd5:    return {s_tx0, s_rx0};
            3'd6:    return {s_sof, (two_ch ? s_rx1 : 16'd0)};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: predict, advance the model, clock the DUTs, compare at negedge.
    task automatic run_cycle();
        logic        nack;
        logic [31:0] e_one;
        bit          clr, snap;
        nack  = 1'b0;
        e_one = 32'd0;
        if (!rst_n) begin
            model_reset();
        end else begin
            nack  = wb_cyc & ~m_ack;
            e_one = nack ? mval(wb_addr, 1'b0) : 32'd0;
            if (nack) exp_q.push_back(mval(wb_addr, 1'b1));
            clr  = nack && wb_we && (wb_addr == 3'd7) && wb_wdata[0];
            snap = nack && wb_we && (wb_addr == 3'd7) && wb_wdata[1];
            if (snap) begin
                s_rx0 = m_rx[0];
                s_tx0 = m_tx[0];
                s_rx1 = m_rx[1];
                s_sof = m_sof;
            end
            for (int i = 0; i < 2; i++) begin
                m_rx[i] = (clr ? 16'd0 : m_rx[i]) + {15'd0, tick_e1_rx[i]};
                m_tx[i] = (clr ? 16'd0 : m_tx[i]) + {15'd0, tick_e1_tx[i]};
            end
            if (tick_usb_sof) m_ts = m_cyc;
            else if (clr)     m_ts = 32'd0;
            m_sof = (clr ? 16'd0 : m_sof) + {15'd0, tick_usb_sof};
            m_cyc = m_cyc + 32'd1;
        end
        m_ack = nack;
        @(posedge clk);
        @(negedge clk);
        check("ack", {31'd0, wb_ack}, {31'd0, nack});
        if (wb_ack) begin
            if (exp_q.size() > 0) check("rdata", wb_rdata, exp_q.pop_front());
            else                  check("unexpected_ack", {31'd0, wb_ack}, 32'd0);
        end else begin
            check("rdata_idle", wb_rdata, 32'd0);
        end
        check("ack_one", {31'd0, one_ack}, {31'd0, nack});
        check("rdata_one", one_rdata, e_one);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wb_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d1);
        wb_cyc  = 1'b1;
        wb_we   = 1'b0;
        wb_addr = a;
        run_cycle();
        d  = wb_rdata;
        d1 = one_rdata;
        wb_cyc = 1'b0;
        run_cycle();
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] data);
        wb_cyc   = 1'b1;
        wb_we    = 1'b1;
        wb_addr  = a;
        wb_wdata = data;
        run_cycle();
        wb_cyc   = 1'b0;
        wb_we    = 1'b0;
        wb_wdata = 32'd0;
        run_cycle();
    endtask

    task automatic pulse(input logic [1:0] rx, input logic [1:0] tx, input logic sof);
        tick_e1_rx   = rx;
        tick_e1_tx   = tx;
        tick_usb_sof = sof;
        run_cycle();
        tick_e1_rx   = 2'b00;
        tick_e1_tx   = 2'b00;
        tick_usb_sof = 1'b0;
        run_cycle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d, d1, a4, n_ts;

        rst_n        = 1'b0;
        tick_e1_rx   = 2'b00;
        tick_e1_tx   = 2'b00;
        tick_usb_sof = 1'b0;
        wb_addr      = 3'd0;
        wb_wdata     = 32'd0;
        wb_we        = 1'b0;
        wb_cyc       = 1'b0;
        model_reset();
        repeat (3) run_cycle();
        rst_n = 1'b1;

        // Idle reads after reset: everything 0 except the cycle counter.
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), d, d1);
            if (a != 4) check($sformatf("idle_addr%0d", a), d, 32'd0);
        end
        wb_read(3'd4, a4, d1);
        repeat (8) run_cycle();
        wb_read(3'd4, d, d1);
        check("cyc_delta_10", d - a4, 32'd10);

        // Five RX and three TX ticks on channel 0.
        repeat (5) pulse(2'b01, 2'b00, 1'b0);
        repeat (3) pulse(2'b00, 2'b01, 1'b0);
        wb_read(3'd0, d, d1);
        check("addr0_rx5_tx3", d, 32'h0003_0005);
        check("addr0_rx5_tx3_one", d1, 32'h0003_0005);

        // SOF timestamps 1000 cycles apart.
        n_ts = m_cyc;
        pulse(2'b00, 2'b00, 1'b1);
        wb_read(3'd3, d, d1);
        check("sof_ts_first", d, n_ts);
        wb_read(3'd2, d, d1);
        check("sof_cnt_1", d, 32'd1);
        while (m_cyc != n_ts + 32'd1000) run_cycle();
        pulse(2'b00, 2'b00, 1'b1);
        wb_read(3'd3, d, d1);
        check("sof_ts_plus1000", d, n_ts + 32'd1000);
        wb_read(3'd2, d, d1);
        check("sof_cnt_2", d, 32'd2);

        // Clear, three TX ticks, then 65537 RX ticks wrap RX to 1.
        wb_write(3'd7, 32'h1);
        repeat (3) pulse(2'b00, 2'b01, 1'b0);
        tick_e1_rx = 2'b01;
        repeat (65537) run_cycle();
        tick_e1_rx = 2'b00;
        wb_read(3'd0, d, d1);
        check("rx_wrap", d, 32'h0003_0001);

        // Snapshot, then four more ticks: live moves, shadow holds.
        wb_write(3'd7, 32'h2);
        repeat (4) pulse(2'b01, 2'b00, 1'b0);
        wb_read(3'd0, d, d1);
        check("live_after_snap", d, 32'h0003_0005);
        wb_read(3'd5, d, d1);
        check("shadow_after_snap", d, 32'h0003_0001);

        // Clear with a same-edge RX tick keeps the tick.
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 3'd7; wb_wdata = 32'h1;
        tick_e1_rx = 2'b01;
        run_cycle();
        tick_e1_rx = 2'b00; wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = 32'd0;
        run_cycle();
        wb_read(3'd0, d, d1);
        check("clear_with_tick", d, 32'h0000_0001);

        // Clear+snapshot in one write with a same-edge SOF.
        pulse(2'b00, 2'b01, 1'b1);
        pulse(2'b00, 2'b00, 1'b1);
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 3'd7; wb_wdata = 32'h3;
        tick_usb_sof = 1'b1;
        n_ts = m_cyc;
        run_cycle();
        tick_usb_sof = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = 32'd0;
        run_cycle();
        wb_read(3'd5, d, d1);
        check("snap_preclear_a5", d, 32'h0001_0001);
        wb_read(3'd6, d, d1);
        check("snap_preclear_a6", d, 32'h0002_0000);
        check("snap_preclear_a6_one", d1, 32'h0002_0000);
        wb_read(3'd2, d, d1);
        check("clear_sof_cnt", d, 32'd1);
        wb_read(3'd3, d, d1);
        check("clear_sof_ts", d, n_ts);

        // Writes outside the CSR are ignored.
        for (int a = 0; a < 7; a++) wb_write(3'(a), 32'hFFFF_FFFF);
        wb_read(3'd0, d, d1);
        check("ignored_writes", d, 32'h0000_0000);

        // Randomised traffic against the model.
        repeat (3000) begin
            tick_e1_rx   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            tick_e1_tx   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            tick_usb_sof = ($urandom_range(0, 15) == 0);
            wb_cyc       = ($urandom_range(0, 2) != 0);
            wb_addr      = 3'($urandom_range(0, 7));
            wb_we        = ($urandom_range(0, 3) == 0);
            wb_wdata     = $urandom;
            if (wb_addr == 3'd7 && $urandom_range(0, 7) != 0) wb_wdata[0] = 1'b0;
            run_cycle();
        end
        tick_e1_rx = 2'b00; tick_e1_tx = 2'b00; tick_usb_sof = 1'b0;
        wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = 32'd0;
        run_cycle();

        // Reset in the middle of an acked read.
        wb_cyc = 1'b1; wb_addr = 3'd4;
        run_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_rdata", wb_rdata, 32'd0);
        check("rst_ack_one", {31'd0, one_ack}, 32'd0);
        wb_cyc = 1'b0;
        repeat (2) run_cycle();
        rst_n = 1'b1;

        // Address 1 on the single-channel instance stays 0 whatever ticks arrive.
        repeat (3) pulse(2'b11, 2'b00, 1'b0);
        pulse(2'b11, 2'b11, 1'b0);
        wb_read(3'd1, d, d1);
        check("addr1_two_ch", d, 32'h0001_0004);
        check("addr1_one_ch", d1, 32'd0);

        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
